sprite_pixel_fifo: RTL and testbench
====================================

Name: sprite_pixel_fifo

Overview:
- 8-slot sprite pixel FIFO directly downstream of the sprite fetcher.
- Accepts a row of 8 sprite pixels when the fetcher presents valid pixels, and merges them into any slots already occupied.
  - Lower-X sprites win; only transparent (colour 0) or empty slots are overwritten.
- Shifts one pixel per pop to the pixel mixer.
- Reports `empty_out`, which feeds the fetcher's `sprite_fifo_empty_in`.

Parameters:
- DEPTH, 8, number of pixel slots (one tile row); only 8 is supported.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- tclk_in  input  1  T-cycle enable; load and pop act only when high
- flush_in  input  1  synchronous clear of all slots, e.g. at scanline end; not gated by `tclk_in`
- load_in  input  1  fetcher pixels valid (`valid_pixels_out`)
- pixels_in  input  2x8  `pixels_in[i]`: colour index of pixel i; i=0 is leftmost
- palette_in  input  1  OBP select for the loaded row (OAM flag bit 4)
- priority_in  input  1  BG-over-OBJ flag for the loaded row (OAM flag bit 7)
- pop_in  input  1  mixer consumes the head pixel this T-cycle
- empty_out  output  1  high when count == 0
- count_out  output  4  occupied slot count, 0..8
- pixel_out  output  2  head slot colour
- palette_out  output  1  head slot palette
- priority_out  output  1  head slot priority
- pixel_valid_out  output  1  head slot occupied

Behaviour:
- Slot storage:
  - Each slot holds {occ, colour[1:0], palette, priority}.
  - Slot 0 is the head.
  - Occupied slots are always contiguous from slot 0, so count == number of occupied slots.
- Reset (async, rst_in=1):
  - All slots cleared to 0, count=0.
  - Outputs: empty_out=1, count_out=0, pixel_out=0, palette_out=0, priority_out=0, pixel_valid_out=0.
  - Reset mid-operation discards all contents immediately.
- Head outputs are combinational from slot 0; zero when slot 0 is unoccupied.
- `empty_out` and `count_out` are combinational from the count register.
- Per clk edge, evaluated in order flush > (pop then load):
  - flush_in=1:
    - All slots cleared, count=0.
    - Load/pop in the same cycle are ignored.
  - tclk_in=0: hold all state.
  - Pop (tclk_in=1, pop_in=1, count>0):
    - Slots shift down one position: slot k takes slot k+1.
    - Slot 7 is cleared.
    - count decrements by 1.
  - Pop on empty is ignored; no underflow, count stays 0.
  - Load (tclk_in=1, load_in=1) is applied to the post-pop contents. For each i in 0..7:
    - If slot i is unoccupied, or occupied with colour 0, it takes {1, pixels_in[i], palette_in, priority_in}.
    - Otherwise slot i is unchanged.
    - After a load, count=8 and all slots are occupied.
    - A loaded colour 0 is occupied-transparent, not empty.
- Simultaneous pop and load:
  - Head pixel is output and removed first.
  - The new row merges into shifted slots 0..7.
  - Net count=8.
- Repeated `load_in` with the same row while no pop occurs is idempotent: non-zero slots are kept, and zero slots are rewritten with the same value.
- Latency:
  - A load on edge N is visible at the head outputs after edge N; empty_out drops the same cycle.
  - Pop-to-next-head is 1 clk.
- Width: count is 4-bit, never exceeds 8, never wraps.

Test Plan:
- Reset → after async assert mid-cycle (no clk edge): empty_out=1, count_out=0, pixel_valid_out=0.
- Load into empty FIFO: pixels {3,2,1,0,3,2,1,0}, palette 1, priority 0, tclk_in=1.
  - After the edge: count_out=8, pixel_out=3, palette_out=1, empty_out=0.
- Pop sequence after the above load: 8 pops with tclk_in=1.
  - pixel_out sequence is 2,1,0,3,2,1,0.
  - After the 8th pop: empty_out=1, pixel_valid_out=0.
  - A 9th pop leaves count_out=0.
- Merge: FIFO holds {1,0,2,0,0,0,0,0} palette 0; load {3,3,3,3,3,3,3,3} palette 1.
  - Head sequence: (1,p0),(3,p1),(2,p0),(3,p1)×5.
- Simultaneous pop+load: FIFO holds {2,1} (count 2); pop and load {3,0,0,0,0,0,0,0} on the same edge.
  - Head becomes 1 (old slot 1 wins), slot 1 becomes 0 occupied.
  - count_out=8.
- Gating/flush:
  - load_in=1 with tclk_in=0 → no change.
  - flush_in=1 with pop_in=1 and load_in=1 → count_out=0, empty_out=1.

Source files
------------

// File: rtl/sprite_pixel_fifo_if.sv
// Fetcher/mixer-facing signal bundle of the sprite pixel FIFO.
// The master side drives rows and pops; the slave side is the FIFO itself.
interface sprite_pixel_fifo_if;
    logic             tclk_in;
    logic             flush_in;
    logic             load_in;
    logic [7:0][1:0]  pixels_in;
    logic             palette_in;
    logic             priority_in;
    logic             pop_in;
    logic             empty_out;
    logic [3:0]       count_out;
    logic [1:0]       pixel_out;
    logic             palette_out;
    logic             priority_out;
    logic             pixel_valid_out;

    modport master (
        output tclk_in, flush_in, load_in, pixels_in, palette_in, priority_in, pop_in,
        input  empty_out, count_out, pixel_out, palette_out, priority_out, pixel_valid_out
    );

    modport slave (
        input  tclk_in, flush_in, load_in, pixels_in, palette_in, priority_in, pop_in,
        output empty_out, count_out, pixel_out, palette_out, priority_out, pixel_valid_out
    );
endinterface

// File: rtl/sprite_pixel_fifo.sv
// 8-slot sprite pixel FIFO: merges fetched sprite rows into transparent/empty
// slots (earlier sprites win) and shifts one pixel per pop towards the mixer.
module sprite_pixel_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    sprite_pixel_fifo_if.slave  bus
);
    typedef struct packed {
        logic       occ;
        logic [1:0] colour;
        logic       palette;
        logic       prio;
    } slot_t;

    slot_t      slot_q  [DEPTH];
    slot_t      slot_d  [DEPTH];
    slot_t      shift_d [DEPTH];
    logic [3:0] count_q;
    logic [3:0] count_d;

    logic do_pop;
    logic do_load;

    assign do_pop  = bus.tclk_in && bus.pop_in && (count_q != 4'd0);
    assign do_load = bus.tclk_in && bus.load_in;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // The loaded row merges into the post-pop contents.
            if (gi == DEPTH - 1) begin : g_tail
                assign shift_d[gi] = do_pop ? slot_t'(0) : slot_q[gi];
            end else begin : g_body
                assign shift_d[gi] = do_pop ? slot_q[gi+1] : slot_q[gi];
            end

            always_comb begin
                slot_d[gi] = shift_d[gi];
                if (bus.flush_in) begin
                    slot_d[gi] = '0;
                end else if (do_load &&
                             (!shift_d[gi].occ || shift_d[gi].colour == 2'd0)) begin
                    slot_d[gi] = '{occ: 1'b1, colour: bus.pixels_in[gi],
                                   palette: bus.palette_in, prio: bus.priority_in};
                end
            end

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (bus.flush_in) begin
            count_d = 4'd0;
        end else if (do_load) begin
            count_d = 4'(DEPTH);
        end else if (do_pop) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.empty_out       = (count_q == 4'd0);
    assign bus.count_out       = count_q;
    assign bus.pixel_valid_out = slot_q[0].occ;
    assign bus.pixel_out       = slot_q[0].occ ? slot_q[0].colour : 2'd0;
    assign bus.palette_out     = slot_q[0].occ && slot_q[0].palette;
    assign bus.priority_out    = slot_q[0].occ && slot_q[0].prio;
endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Randomized self-checking bench for sprite_pixel_fifo against a queue-based
// reference model, preceded by the directed scenarios for load/pop/merge/flush.
module tb_sprite_pixel_fifo;
    logic clk;
    logic rst;

    sprite_pixel_fifo_if bus ();

    sprite_pixel_fifo #(.DEPTH(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] c;
        bit         pal;
        bit         pri;
    } px_t;

    px_t model_q[$];
    int  n_vec;
    int  n_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"}, int'(bus.count_out), sz);
        chk({tag, ".empty"}, int'(bus.empty_out), (sz == 0) ? 1 : 0);
        chk({tag, ".valid"}, int'(bus.pixel_valid_out), (sz > 0) ? 1 : 0);
        chk({tag, ".pixel"}, int'(bus.pixel_out), (sz > 0) ? int'(model_q[0].c) : 0);
        chk({tag, ".pal"}, int'(bus.palette_out), (sz > 0) ? int'(model_q[0].pal) : 0);
        chk({tag, ".pri"}, int'(bus.priority_out), (sz > 0) ? int'(model_q[0].pri) : 0);
    endtask

    // Reference behaviour: flush wins, then pop the head, then merge the row.
    task automatic model_step();
        px_t np;
        if (bus.flush_in) begin
            model_q.delete();
        end else if (bus.tclk_in) begin
            if (bus.pop_in && model_q.size() > 0) void'(model_q.pop_front());
            if (bus.load_in) begin
                for (int i = 0; i < 8; i++) begin
                    np.c   = bus.pixels_in[i];
                    np.pal = bus.palette_in;
                    np.pri = bus.priority_in;
                    if (i >= model_q.size()) model_q.push_back(np);
                    else if (model_q[i].c == 2'd0) model_q[i] = np;
                end
            end
        end
    endtask

    task automatic cyc(input bit t, input bit f, input bit l, input bit p,
                       input logic [7:0][1:0] px, input bit pal, input bit pri,
                       input string tag);
        bus.tclk_in     = t;
        bus.flush_in    = f;
        bus.load_in     = l;
        bus.pop_in      = p;
        bus.pixels_in   = px;
        bus.palette_in  = pal;
        bus.priority_in = pri;
        @(posedge clk);
        #1;
        model_step();
        chk_model(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #2;
        model_q.delete();
        chk_model(tag);
        rst = 1'b0;
    endtask

    function automatic logic [7:0][1:0] row(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][1:0] r;
        r[0] = 2'(a0); r[1] = 2'(a1); r[2] = 2'(a2); r[3] = 2'(a3);
        r[4] = 2'(a4); r[5] = 2'(a5); r[6] = 2'(a6); r[7] = 2'(a7);
        return r;
    endfunction

    initial begin
        logic [7:0][1:0] zrow;
        int exp_seq[7];
        n_vec = 0;
        n_err = 0;
        zrow  = '0;
        rst   = 1'b0;
        bus.tclk_in = 1'b0; bus.flush_in = 1'b0; bus.load_in = 1'b0;
        bus.pop_in = 1'b0; bus.pixels_in = '0; bus.palette_in = 1'b0;
        bus.priority_in = 1'b0;
        #3;
        async_reset("reset");

        // Load into empty, then drain with 9 pops.
        cyc(1, 0, 1, 0, row(3,2,1,0,3,2,1,0), 1, 0, "load");
        chk("load.head3", int'(bus.pixel_out), 3);
        chk("load.cnt8", int'(bus.count_out), 8);
        exp_seq = '{2, 1, 0, 3, 2, 1, 0};
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0, 1, zrow, 0, 0, "pop");
            chk("pop.seq", int'(bus.pixel_out), exp_seq[i]);
        end
        cyc(1, 0, 0, 1, zrow, 0, 0, "pop8");
        chk("pop8.empty", int'(bus.empty_out), 1);
        cyc(1, 0, 0, 1, zrow, 0, 0, "pop9");
        chk("pop9.cnt0", int'(bus.count_out), 0);

        // Merge into partially transparent row.
        cyc(1, 0, 1, 0, row(1,0,2,0,0,0,0,0), 0, 0, "merge.base");
        cyc(1, 0, 1, 0, row(3,3,3,3,3,3,3,3), 1, 1, "merge.load");
        cyc(1, 0, 1, 0, row(3,3,3,3,3,3,3,3), 1, 1, "merge.idem");
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, zrow, 0, 0, "merge.pop");

        // Simultaneous pop and load with two resident pixels.
        cyc(1, 0, 1, 0, row(1,1,1,1,1,1,2,1), 0, 1, "pl.base");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, zrow, 0, 0, "pl.drain");
        cyc(1, 0, 1, 1, row(3,0,0,0,0,0,0,0), 1, 0, "pl.both");
        chk("pl.head1", int'(bus.pixel_out), 1);
        cyc(1, 0, 0, 1, zrow, 0, 0, "pl.next");
        chk("pl.slot1occ0", int'(bus.pixel_valid_out), 1);

        // Gating and flush priority.
        cyc(0, 0, 1, 1, row(2,2,2,2,2,2,2,2), 1, 1, "gate");
        cyc(1, 1, 1, 1, row(2,2,2,2,2,2,2,2), 1, 1, "flush");
        chk("flush.empty", int'(bus.empty_out), 1);
        cyc(1, 0, 1, 0, row(1,2,3,0,1,2,3,0), 0, 1, "refill");
        cyc(0, 1, 0, 0, zrow, 0, 0, "flush.notclk");
        cyc(1, 0, 1, 0, row(2,0,1,0,3,0,2,0), 1, 0, "refill2");
        async_reset("reset.mid");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0][1:0] rpx;
            rpx = 16'($urandom);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                rpx, 1'($urandom), 1'($urandom), "rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand.reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
